alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
Control FSM for the alarm-clock timekeeper. It owns the alarm-time configuration registers and drives them into the timekeeper's alarm compare inputs. It provides button-driven alarm setting, arm/disarm, a buzzer output with ring timeout, and a bounded snooze. It sits between the debounced user buttons and the clock counter, and consumes the counter's current hours/minutes and seconds tick.

Parameters:
HW, 2, width of hours fields
MW, 3, width of minutes fields
RING_TIMEOUT, 8, ticks the buzzer rings before auto-stop (>=1)
SNOOZE_TICKS, 4, ticks spent silent in snooze before re-ringing (>=1)
MAX_SNOOZE, 3, snoozes allowed per alarm event
CW, 4, width of internal tick counters (must hold max(RING_TIMEOUT, SNOOZE_TICKS)-1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle pulse per timekeeper seconds advance
cur_hours  in  HW  current hours from timekeeper
cur_minutes  in  MW  current minutes from timekeeper
btn_set  in  1  one-cycle pulse: enter setting / advance field
btn_inc  in  1  one-cycle pulse: increment field being set
btn_snooze  in  1  one-cycle pulse: snooze
btn_off  in  1  one-cycle pulse: stop ringing / disarm / abort setting
alarm_hours  out  HW  configured alarm hour (to timekeeper)
alarm_minutes  out  MW  configured alarm minute (to timekeeper)
buzzer  out  1  high while ringing
armed  out  1  high in ARMED, RINGING, SNOOZE
state  out  3  IDLE=0, SET_H=1, SET_M=2, ARMED=3, RINGING=4, SNOOZE=5
snooze_cnt  out  2  snoozes used in current alarm event

Behaviour:
- Reset, asynchronous, active-high; clock clk.
- On reset: state=IDLE, alarm_hours=0, alarm_minutes=0, buzzer=0, armed=0, snooze_cnt=0, internal ring/snooze counters=0, match_q=0.
- All outputs are registered. A button on cycle n produces its state/output effect on cycle n+1.
- buzzer and armed are decoded from the next state, so they align with state.
- Button priority within one cycle: off > snooze > set > inc. Lower-priority buttons in the same cycle are ignored.
- A button transition in the same cycle as tick takes precedence; that tick is not counted.
- match = (cur_hours==alarm_hours) && (cur_minutes==alarm_minutes). match_q <= match every cycle in every state.
- IDLE: btn_set -> SET_H. All other buttons are ignored.
- SET_H:
  - btn_inc: alarm_hours+1, wrapping modulo 2^HW.
  - btn_set -> SET_M.
  - btn_off -> IDLE; edited value is retained.
- SET_M:
  - btn_inc: alarm_minutes+1, wrapping modulo 2^MW.
  - btn_set -> ARMED.
  - btn_off -> IDLE.
- ARMED:
  - Rising edge (match && !match_q) -> RINGING; ring_cnt=0, snooze_cnt=0.
  - btn_off -> IDLE.
  - btn_set -> SET_H.
  - If match is already true on entry to ARMED, no ring until the next rising edge (i.e. after the timekeeper wraps back around).
- RINGING:
  - On each tick, ring_cnt++. On a tick with ring_cnt==RING_TIMEOUT-1 -> ARMED (auto-stop).
  - btn_off -> ARMED.
  - btn_snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt++, snz_cnt=0.
  - btn_snooze with snooze_cnt==MAX_SNOOZE is ignored; ringing continues.
- SNOOZE:
  - On each tick, snz_cnt++. On a tick with snz_cnt==SNOOZE_TICKS-1 -> RINGING; ring_cnt=0.
  - btn_off -> ARMED.
  - btn_snooze is ignored.
- snooze_cnt holds its value after return to ARMED and is cleared only on the next alarm trigger or on reset.
- alarm_hours/alarm_minutes change only in SET_H/SET_M.
- Reset mid-ring or mid-set returns immediately to the reset values; the configuration is lost.

Test Plan:
- Reset, then set/inc/inc/set/inc×5/set -> alarm_hours=2, alarm_minutes=5, state=ARMED, armed=1. In SET_H, inc×4 from 3 wraps hours to 3 (3->0->1->2->3).
- Armed at 2:5; drive cur 2:4 then 2:5 -> state=RINGING and buzzer=1 one cycle after the match edge. Send 8 ticks -> state=ARMED, buzzer=0 after the 8th tick.
- Ringing; btn_snooze -> SNOOZE, buzzer=0, snooze_cnt=1. 4 ticks -> RINGING. Repeat to snooze_cnt=3; 4th btn_snooze ignored, buzzer stays 1; btn_off -> ARMED.
- Arm while cur already equals alarm (cur 2:5 held) -> no ring. Move cur to 2:6, then wrap back to 2:5 -> rings.
- Same cycle btn_off+btn_snooze while RINGING -> ARMED, snooze_cnt unchanged. Same cycle tick+btn_snooze at ring_cnt=7 -> SNOOZE, not ARMED.
- Assert reset asynchronously mid-RINGING (between clock edges) -> buzzer=0, state=0, alarm_hours=0, alarm_minutes=0 immediately.

Source files
------------

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm-time registers, set/arm/ring/snooze control FSM for the timekeeper.
module alarm_sequencer #(
    parameter int HW           = 2,
    parameter int MW           = 3,
    parameter int RING_TIMEOUT = 8,
    parameter int SNOOZE_TICKS = 4,
    parameter int MAX_SNOOZE   = 3,
    parameter int CW           = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic [HW-1:0] cur_hours,
    input  logic [MW-1:0] cur_minutes,
    input  logic          btn_set,
    input  logic          btn_inc,
    input  logic          btn_snooze,
    input  logic          btn_off,
    output logic [HW-1:0] alarm_hours,
    output logic [MW-1:0] alarm_minutes,
    output logic          buzzer,
    output logic          armed,
    output logic [2:0]    state,
    output logic [1:0]    snooze_cnt
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_H   = 3'd1,
        SET_M   = 3'd2,
        ARMED   = 3'd3,
        RINGING = 3'd4,
        SNOOZE  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hours_q, hours_d;
    logic [MW-1:0] minutes_q, minutes_d;
    logic [CW-1:0] ring_q, ring_d, snz_q, snz_d;
    logic [1:0]    sc_q, sc_d;
    logic          buzzer_q, buzzer_d, armed_q, armed_d, match_q, match;

    assign match = (cur_hours == hours_q) && (cur_minutes == minutes_q);

    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        ring_d    = ring_q;
        snz_d     = snz_q;
        sc_d      = sc_q;
        case (state_q)
            IDLE: if (btn_set) state_d = SET_H;
            SET_H: begin
                if (btn_off) state_d = IDLE;
                else if (btn_set) state_d = SET_M;
                else if (btn_inc) hours_d = hours_q + 1'b1;
            end
            SET_M: begin
                if (btn_off) state_d = IDLE;
                else if (btn_set) state_d = ARMED;
                else if (btn_inc) minutes_d = minutes_q + 1'b1;
            end
            ARMED: begin
                if (btn_off) state_d = IDLE;
                else if (btn_set) state_d = SET_H;
                else if (match && !match_q) begin
                    state_d = RINGING;
                    ring_d  = '0;
                    sc_d    = '0;
                end
            end
            RINGING: begin
                if (btn_off) state_d = ARMED;
                else if (btn_snooze && sc_q < 2'(MAX_SNOOZE)) begin
                    state_d = SNOOZE;
                    sc_d    = sc_q + 1'b1;
                    snz_d   = '0;
                end else if (tick) begin
                    ring_d  = ring_q + 1'b1;
                    state_d = (ring_q == CW'(RING_TIMEOUT - 1)) ? ARMED : RINGING;
                end
            end
            SNOOZE: begin
                if (btn_off) state_d = ARMED;
                else if (tick && snz_q == CW'(SNOOZE_TICKS - 1)) begin
                    state_d = RINGING;
                    ring_d  = '0;
                end else if (tick) snz_d = snz_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Decoded from the next state so the registered flags line up with state.
        buzzer_d = state_d == RINGING;
        armed_d  = state_d == ARMED || state_d == RINGING || state_d == SNOOZE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hours_q   <= '0;
            minutes_q <= '0;
            ring_q    <= '0;
            snz_q     <= '0;
            sc_q      <= '0;
            buzzer_q  <= 1'b0;
            armed_q   <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            ring_q    <= ring_d;
            snz_q     <= snz_d;
            sc_q      <= sc_d;
            buzzer_q  <= buzzer_d;
            armed_q   <= armed_d;
            match_q   <= match;
        end
    end

    assign alarm_hours   = hours_q;
    assign alarm_minutes = minutes_q;
    assign buzzer        = buzzer_q;
    assign armed         = armed_q;
    assign state         = state_q;
    assign snooze_cnt    = sc_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed and randomized checks of alarm_sequencer against a countdown-based model.
module tb_alarm_sequencer;
    localparam int RT = 8, ST = 4, MAXS = 3;

    logic       clk = 0, reset = 1, tick = 0;
    logic [1:0] cur_hours = 0;
    logic [2:0] cur_minutes = 0;
    logic       btn_set = 0, btn_inc = 0, btn_snooze = 0, btn_off = 0;
    logic [1:0] alarm_hours;
    logic [2:0] alarm_minutes;
    logic       buzzer, armed;
    logic [2:0] state;
    logic [1:0] snooze_cnt;

    int vectors = 0, miscompares = 0;
    int m_st, m_ah, m_am, m_sc, m_ring_left, m_snz_left;
    bit m_prev;

    alarm_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes),
        .btn_set(btn_set), .btn_inc(btn_inc), .btn_snooze(btn_snooze), .btn_off(btn_off),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .buzzer(buzzer), .armed(armed), .state(state), .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    wire [11:0] got = {state, alarm_hours, alarm_minutes, buzzer, armed, snooze_cnt};

    function automatic logic [11:0] expv();
        return {3'(m_st), 2'(m_ah), 3'(m_am), 1'(m_st == 4), 1'(m_st >= 3 && m_st <= 5), 2'(m_sc)};
    endfunction

    function automatic void model_reset();
        m_st = 0; m_ah = 0; m_am = 0; m_sc = 0; m_ring_left = 0; m_snz_left = 0; m_prev = 0;
    endfunction

    // Modes: 0 idle, 1 set hours, 2 set minutes, 3 armed, 4 ringing, 5 snoozing.
    // Ring and snooze periods are modelled as remaining-tick countdowns.
    function automatic void model(bit t, bit s, bit i, bit z, bit o);
        bit m = (int'(cur_hours) == m_ah) && (int'(cur_minutes) == m_am);
        case (m_st)
            0: if (s) m_st = 1;
            1: if (o) m_st = 0; else if (s) m_st = 2; else if (i) m_ah = (m_ah + 1) % 4;
            2: if (o) m_st = 0; else if (s) m_st = 3; else if (i) m_am = (m_am + 1) % 8;
            3: if (o) m_st = 0; else if (s) m_st = 1;
               else if (m && !m_prev) begin m_st = 4; m_ring_left = RT; m_sc = 0; end
            4: if (o) m_st = 3;
               else if (z && m_sc < MAXS) begin m_st = 5; m_sc++; m_snz_left = ST; end
               else if (t) begin m_ring_left--; if (m_ring_left == 0) m_st = 3; end
            5: if (o) m_st = 3;
               else if (t) begin m_snz_left--; if (m_snz_left == 0) begin m_st = 4; m_ring_left = RT; end end
            default: m_st = 0;
        endcase
        m_prev = m;
    endfunction

    task automatic cyc(input bit t, input bit s, input bit i, input bit z, input bit o);
        tick = t; btn_set = s; btn_inc = i; btn_snooze = z; btn_off = o;
        model(t, s, i, z, o);
        @(posedge clk);
        @(negedge clk);
        tick = 0; btn_set = 0; btn_inc = 0; btn_snooze = 0; btn_off = 0;
    endtask

    task automatic set_cur(input int h, input int m);
        cur_hours = 2'(h); cur_minutes = 3'(m);
    endtask

    task automatic test_reset();
        reset = 1; model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (got !== expv()) begin miscompares++; $display("FAIL reset got=%h exp=%h", got, expv()); end
        reset = 0;
    endtask

    task automatic test_set_wrap();
        cyc(0,1,0,0,0); cyc(0,0,1,0,0); cyc(0,0,1,0,0);
        vectors++;
        if (got !== expv() || alarm_hours !== 2'd2 || state !== 3'd1) begin miscompares++; $display("FAIL set_hours got=%h exp=%h", got, expv()); end
        cyc(0,1,0,0,0);
        repeat (5) cyc(0,0,1,0,0);
        cyc(0,1,0,0,0);
        vectors++;
        if (got !== expv() || alarm_minutes !== 3'd5 || state !== 3'd3 || armed !== 1'b1) begin miscompares++; $display("FAIL set_armed got=%h exp=%h", got, expv()); end
        cyc(0,1,0,0,0); cyc(0,0,1,0,0);
        repeat (4) cyc(0,0,1,0,0);
        vectors++;
        if (got !== expv() || alarm_hours !== 2'd3) begin miscompares++; $display("FAIL hour_wrap got=%h exp=%h", got, expv()); end
        repeat (3) cyc(0,0,1,0,0);
        cyc(0,1,0,0,0); cyc(0,1,0,0,0);
        vectors++;
        if (got !== expv() || alarm_hours !== 2'd2 || alarm_minutes !== 3'd5) begin miscompares++; $display("FAIL rearm got=%h exp=%h", got, expv()); end
    endtask

    task automatic test_ring_timeout();
        set_cur(2,4); cyc(0,0,0,0,0);
        set_cur(2,5); cyc(0,0,0,0,0);
        vectors++;
        if (got !== expv() || state !== 3'd4 || buzzer !== 1'b1) begin miscompares++; $display("FAIL ring_start got=%h exp=%h", got, expv()); end
        repeat (7) cyc(1,0,0,0,0);
        vectors++;
        if (got !== expv() || buzzer !== 1'b1) begin miscompares++; $display("FAIL ring_7ticks got=%h exp=%h", got, expv()); end
        cyc(1,0,0,0,0);
        vectors++;
        if (got !== expv() || state !== 3'd3 || buzzer !== 1'b0) begin miscompares++; $display("FAIL ring_timeout got=%h exp=%h", got, expv()); end
    endtask

    task automatic test_snooze();
        set_cur(0,0); cyc(0,0,0,0,0);
        set_cur(2,5); cyc(0,0,0,0,0);
        for (int k = 1; k <= 3; k++) begin
            cyc(0,0,0,1,0);
            vectors++;
            if (got !== expv() || state !== 3'd5 || buzzer !== 1'b0 || snooze_cnt !== 2'(k)) begin miscompares++; $display("FAIL snooze_enter%0d got=%h exp=%h", k, got, expv()); end
            cyc(1,0,0,1,0); cyc(1,0,0,0,0); cyc(1,0,0,0,0);
            vectors++;
            if (got !== expv() || state !== 3'd5) begin miscompares++; $display("FAIL snooze_hold%0d got=%h exp=%h", k, got, expv()); end
            cyc(1,0,0,0,0);
            vectors++;
            if (got !== expv() || state !== 3'd4 || buzzer !== 1'b1) begin miscompares++; $display("FAIL snooze_rering%0d got=%h exp=%h", k, got, expv()); end
        end
        cyc(0,0,0,1,0);
        vectors++;
        if (got !== expv() || state !== 3'd4 || buzzer !== 1'b1 || snooze_cnt !== 2'd3) begin miscompares++; $display("FAIL snooze_limit got=%h exp=%h", got, expv()); end
        cyc(0,0,0,0,1);
        vectors++;
        if (got !== expv() || state !== 3'd3 || snooze_cnt !== 2'd3) begin miscompares++; $display("FAIL snooze_off got=%h exp=%h", got, expv()); end
    endtask

    task automatic test_arm_on_match();
        set_cur(0,0); cyc(0,1,0,0,0);
        set_cur(2,5); cyc(0,1,0,0,0); cyc(0,1,0,0,0);
        repeat (3) cyc(0,0,0,0,0);
        vectors++;
        if (got !== expv() || state !== 3'd3 || buzzer !== 1'b0) begin miscompares++; $display("FAIL arm_on_match got=%h exp=%h", got, expv()); end
        set_cur(2,6); cyc(0,0,0,0,0);
        set_cur(2,5); cyc(0,0,0,0,0);
        vectors++;
        if (got !== expv() || state !== 3'd4) begin miscompares++; $display("FAIL match_rewrap got=%h exp=%h", got, expv()); end
        cyc(0,0,0,0,1);
    endtask

    task automatic test_priority();
        set_cur(0,0); cyc(0,0,0,0,0);
        set_cur(2,5); cyc(0,0,0,0,0);
        cyc(0,0,0,1,0);
        repeat (4) cyc(1,0,0,0,0);
        cyc(0,0,0,1,1);
        vectors++;
        if (got !== expv() || state !== 3'd3 || snooze_cnt !== 2'd1) begin miscompares++; $display("FAIL off_over_snooze got=%h exp=%h", got, expv()); end
        set_cur(0,0); cyc(0,0,0,0,0);
        set_cur(2,5); cyc(0,0,0,0,0);
        repeat (7) cyc(1,0,0,0,0);
        cyc(1,0,0,1,0);
        vectors++;
        if (got !== expv() || state !== 3'd5) begin miscompares++; $display("FAIL tick_snooze got=%h exp=%h", got, expv()); end
        cyc(0,0,0,0,1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int b = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0)
                set_cur($urandom_range(0, 3), $urandom_range(0, 1) ? m_am : int'($urandom_range(0, 7)));
            cyc($urandom_range(0, 2) == 0, b == 1, b == 2, b == 3 || b == 4, b == 5);
            vectors++;
            if (got !== expv()) begin miscompares++; $display("FAIL random%0d got=%h exp=%h", n, got, expv()); end
        end
    endtask

    task automatic test_async_reset();
        cyc(0,0,0,0,1); cyc(0,0,0,0,1);
        set_cur((m_ah + 1) % 4, m_am);
        cyc(0,1,0,0,0); cyc(0,1,0,0,0); cyc(0,1,0,0,0);
        set_cur(m_ah, m_am); cyc(0,0,0,0,0);
        vectors++;
        if (got !== expv() || state !== 3'd4) begin miscompares++; $display("FAIL pre_reset_ring got=%h exp=%h", got, expv()); end
        #2 reset = 1;
        model_reset();
        #1;
        vectors++;
        if (got !== 12'h000) begin miscompares++; $display("FAIL async_reset got=%h exp=%h", got, 12'h000); end
        @(negedge clk);
        reset = 0;
        cyc(0,0,0,0,0);
        vectors++;
        if (got !== expv()) begin miscompares++; $display("FAIL post_reset got=%h exp=%h", got, expv()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_set_wrap();
        test_ring_timeout();
        test_snooze();
        test_arm_on_match();
        test_priority();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
